// File: rtl/cam_pkg.sv
// Shared definitions for the DVP camera capture block.
// Holds parameter defaults, RGB565 field widths and the capture FSM state type.
package cam_pkg;

  localparam int H_ACTIVE_DEF    = 800;
  localparam int V_ACTIVE_DEF    = 480;
  localparam int SKIP_FRAMES_DEF = 10;

  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int PIX_W = R_W + G_W + B_W;

  typedef enum logic [1:0] {
    ST_WAIT_VS = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2
  } cam_state_t;

endpackage

// File: rtl/camera_capture_module_if.sv
// Pixel FIFO write port between the capture block (master) and the FIFO (slave).
interface camera_capture_module_if;
  import cam_pkg::*;

  // Handshake: fifo_wr_en is a one-cycle write strobe carrying fifo_wr_data.
  // fifo_full high in a cycle means a strobe at the next rising edge would be lost,
  // so the master suppresses it and reports the drop instead.
  logic             fifo_wr_en;
  logic [PIX_W-1:0] fifo_wr_data;
  logic             fifo_full;

  modport master (output fifo_wr_en, output fifo_wr_data, input fifo_full);
  modport slave  (input fifo_wr_en, input fifo_wr_data, output fifo_full);

endinterface

// File: rtl/dvp_input_sync.sv
// Registers the raw DVP pins once and derives VSYNC-rise / HREF-fall from the registered copies.
module dvp_input_sync (
  input  logic       CLK,
  input  logic       RST,
  input  logic       VSYNC,
  input  logic       HREF,
  input  logic [7:0] cam_data,
  output logic       vsync_q,
  output logic       href_q,
  output logic [7:0] data_q,
  output logic       vs_rise,
  output logic       href_fall
);

  logic vsync_d;
  logic href_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= 8'd0;
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
    end else begin
      vsync_q <= VSYNC;
      href_q  <= HREF;
      data_q  <= cam_data;
      vsync_d <= vsync_q;
      href_d  <= href_q;
    end
  end

  assign vs_rise   = vsync_q & ~vsync_d;
  assign href_fall = href_d & ~href_q;

endmodule

// File: rtl/camera_capture_module.sv
// DVP camera capture: skips settling frames, pairs bytes into RGB565 pixels and
// writes the active window into a pixel FIFO, flagging drops on fifo_full.
module camera_capture_module
  import cam_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int SKIP_FRAMES = SKIP_FRAMES_DEF
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           VSYNC,
  input  logic                           HREF,
  input  logic [7:0]                     cam_data,
  camera_capture_module_if.master        fifo,
  output logic                           frame_start,
  output logic [7:0]                     frame_cnt,
  output logic                           overflow,
  output cam_state_t                     dbg_state
);

  localparam int COL_W = $clog2(H_ACTIVE + 1);
  localparam int ROW_W = $clog2(V_ACTIVE + 1);

  logic       vsync_q, href_q, vs_rise, href_fall;
  logic [7:0] data_q;

  dvp_input_sync u_sync (
    .CLK       (CLK),
    .RST       (RST),
    .VSYNC     (VSYNC),
    .HREF      (HREF),
    .cam_data  (cam_data),
    .vsync_q   (vsync_q),
    .href_q    (href_q),
    .data_q    (data_q),
    .vs_rise   (vs_rise),
    .href_fall (href_fall)
  );

  cam_state_t       state, state_nxt;
  logic [8:0]       skip_cnt;
  logic             enter_frame;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             byte_phase;
  logic             line_has_pix;
  logic [7:0]       hi_byte;
  logic             active;
  logic             in_window;

  assign dbg_state = state;
  assign active    = (state == ST_CAPTURE) && !vsync_q;
  assign in_window = (col < COL_W'(H_ACTIVE)) && (row < ROW_W'(V_ACTIVE));

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_WAIT_VS;
    else     state <= state_nxt;
  end

  // skip_cnt counts every VSYNC rise seen before capture, including the one leaving WAIT_VS.
  always_comb begin
    state_nxt   = state;
    enter_frame = 1'b0;
    case (state)
      ST_WAIT_VS: if (vs_rise) begin
        if (SKIP_FRAMES == 0) begin
          state_nxt   = ST_CAPTURE;
          enter_frame = 1'b1;
        end else begin
          state_nxt = ST_SKIP;
        end
      end
      ST_SKIP: if (vs_rise && skip_cnt == 9'(SKIP_FRAMES)) begin
        state_nxt   = ST_CAPTURE;
        enter_frame = 1'b1;
      end
      ST_CAPTURE: enter_frame = vs_rise;
      default:    state_nxt = ST_WAIT_VS;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      skip_cnt <= 9'd0;
    end else if (vs_rise && state != ST_CAPTURE) begin
      skip_cnt <= skip_cnt + 9'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fifo.fifo_wr_en   <= 1'b0;
      fifo.fifo_wr_data <= '0;
      frame_start       <= 1'b0;
      frame_cnt         <= 8'd0;
      overflow          <= 1'b0;
      col               <= '0;
      row               <= '0;
      byte_phase        <= 1'b0;
      line_has_pix      <= 1'b0;
      hi_byte           <= 8'd0;
    end else begin
      fifo.fifo_wr_en <= 1'b0;
      frame_start     <= 1'b0;
      if (enter_frame) begin
        frame_start  <= 1'b1;
        frame_cnt    <= frame_cnt + 8'd1;
        overflow     <= 1'b0;
        col          <= '0;
        row          <= '0;
        byte_phase   <= 1'b0;
        line_has_pix <= 1'b0;
      end else begin
        if (active && href_q) begin
          byte_phase <= ~byte_phase;
          if (!byte_phase) begin
            hi_byte <= data_q;
          end else begin
            line_has_pix <= 1'b1;
            if (col < COL_W'(H_ACTIVE)) col <= col + 1'b1;
            // A dropped pixel still consumes its column so later pixels keep their position.
            if (in_window) begin
              if (fifo.fifo_full) begin
                overflow <= 1'b1;
              end else begin
                fifo.fifo_wr_en   <= 1'b1;
                fifo.fifo_wr_data <= {hi_byte, data_q};
              end
            end
          end
        end else begin
          byte_phase <= 1'b0;
        end
        if (active && href_fall) begin
          col          <= '0;
          line_has_pix <= 1'b0;
          if (line_has_pix && row < ROW_W'(V_ACTIVE)) row <= row + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/camera_capture_module.md
CAMERA_CAPTURE_MODULE -- requirements
Module: camera_capture_module

Interface
REQ-001 SHALL have parameter H_ACTIVE, 800, pixels written per line; later pixels dropped.
REQ-002 SHALL have parameter V_ACTIVE, 480, lines written per frame; later lines dropped.
REQ-003 SHALL have parameter SKIP_FRAMES, 10, whole frames discarded after reset while sensor settles (range 0..255).
REQ-004 SHALL have port CLK  input  1  camera pixel clock; sole clock, all logic on its rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port VSYNC  input  1  DVP frame sync, active-high; high = vertical blanking.
REQ-007 SHALL have port HREF  input  1  DVP line valid, active-high.
REQ-008 SHALL have port cam_data  input  8  DVP byte, valid while HREF high.
REQ-009 SHALL have port fifo_full  input  1  pixel FIFO cannot accept a write this cycle.
REQ-010 SHALL have port fifo_wr_en  output  1  single-cycle FIFO write strobe.
REQ-011 SHALL have port fifo_wr_data  output  16  RGB565 pixel, R[15:11] G[10:5] B[4:0].
REQ-012 SHALL have port frame_start  output  1  one-cycle pulse at start of each captured frame.
REQ-013 SHALL have port frame_cnt  output  8  captured-frame count, wraps 255->0.
REQ-014 SHALL have port overflow  output  1  sticky: pixel dropped on fifo_full in current frame.

Function
REQ-015 SHALL register VSYNC, HREF, cam_data once on CLK before any use; all edges detected on registered copies.
REQ-016 SHALL implement FSM WAIT_VS -> SKIP -> CAPTURE; WAIT_VS exits on first VSYNC rising edge.
REQ-017 SHALL in SKIP count VSYNC rising edges, entering CAPTURE on the edge at which the count (including the exiting WAIT_VS edge) equals SKIP_FRAMES+1; SKIP_FRAMES=0 goes straight to CAPTURE on that first edge.
REQ-018 SHALL on each VSYNC rising edge in CAPTURE, and on the edge entering CAPTURE: pulse frame_start next cycle, zero row/column counters, clear overflow, increment frame_cnt (not in WAIT_VS/SKIP).
REQ-019 SHALL pair bytes while HREF high: first byte = fifo_wr_data[15:8], second = [7:0]; byte-phase clears whenever HREF low, so an odd trailing byte is discarded.
REQ-020 SHALL count columns per completed pixel from 0, saturating at H_ACTIVE; clear on HREF falling edge.
REQ-021 SHALL increment row on HREF falling edge only when that line completed at least one pixel; saturate at V_ACTIVE.
REQ-022 SHALL assert fifo_wr_en only in CAPTURE, VSYNC low, column<H_ACTIVE, row<V_ACTIVE, fifo_full low.
REQ-023 SHALL assert fifo_wr_en exactly 2 CLK after second byte of a pixel is present on cam_data (input register + output register), fifo_full sampled in the cycle before the strobe.
REQ-024 SHALL, when a pixel is otherwise writable but fifo_full high, drop it, set overflow, and still advance column.
REQ-025 SHALL hold fifo_wr_data stable when fifo_wr_en low (last written value).
REQ-026 SHALL ignore HREF activity while VSYNC high and in WAIT_VS/SKIP (no writes, no counter change).

Reset
REQ-027 SHALL on RST high: FSM=WAIT_VS, skip counter=0, row=column=0, byte-phase=0, input registers=0.
REQ-028 SHALL on RST high drive fifo_wr_en=0, fifo_wr_data=0, frame_start=0, frame_cnt=0, overflow=0.
REQ-029 SHALL on RST mid-frame abandon any half pixel and restart the full SKIP sequence.

Structure
REQ-030 SHALL place FSM state enum, RGB565 field widths, and parameter defaults in shared package cam_pkg.
REQ-031 SHALL use one sub-module dvp_input_sync (input registers plus VSYNC rise / HREF fall detection).

Verification
REQ-032 SHALL test SKIP_FRAMES=2, four frames 800x480: no writes in first two, frame_cnt=1 then 2, 384000 writes each captured frame.
REQ-033 SHALL test bytes 0xF8,0x1F on one pixel -> fifo_wr_data=0xF81F, fifo_wr_en exactly 2 CLK after 0x1F presented.
REQ-034 SHALL test 1000-pixel lines, 600 lines -> only first 800 pixels of first 480 lines written.
REQ-035 SHALL test line of 3 bytes (0x12,0x34,0x56) -> one write 0x1234, byte 0x56 discarded, next line starts high byte.
REQ-036 SHALL test fifo_full high for pixels 10..12 -> those three dropped, overflow=1 until next frame_start, pixel 13 written at column 13.
REQ-037 SHALL test RST pulse at row 200 -> outputs zeroed next cycle, no writes until SKIP_FRAMES+1 further VSYNC edges.
